// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions for the iterative compression engine:
//   - word_t / hstate_t : 32-bit word and the eight-word chaining state a..h
//                         (element 0 = a, which is also the MSB word)
//   - state_t           : control FSM encoding for sha_compress_iter
//   - K, IV             : round-constant table and initial hash value
//   - bsig0/bsig1/ssig0/ssig1/ch/maj : the SHA-256 logical functions
// -----------------------------------------------------------------------------
package sha256_pkg;

   typedef logic [31:0]       word_t;
   typedef logic [0:7][31:0]  hstate_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam word_t IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t bsig0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t bsig1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ssig0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ssig1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha_w_expand.sv
// -----------------------------------------------------------------------------
// sha_w_expand
// Combinational message-schedule step for RPC rounds per clock.
//   win      : 16-word window, element 0 = W[t] for the current round t
//   sched    : W[t] .. W[t+RPC-1], one word per unrolled round
//   win_next : window advanced by RPC words (W[t+RPC] .. W[t+RPC+15])
// The window register itself lives in the parent.
// -----------------------------------------------------------------------------
module sha_w_expand
   import sha256_pkg::*;
#(
   parameter int RPC = 1
) (
   input  logic [0:15][31:0]    win,
   output logic [0:RPC-1][31:0] sched,
   output logic [0:15][31:0]    win_next
);

   // Window extended by the RPC words that follow it. The recurrence is valid
   // for any window position, so words 16.. are always computed; during the
   // first 16 rounds they simply become the upcoming schedule entries.
   word_t ext [0:15+RPC];

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         ext[i] = win[i];
      end
      for (int i = 16; i < 16 + RPC; i++) begin
         ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
      end
      for (int j = 0; j < RPC; j++) begin
         sched[j] = ext[j];
      end
      for (int i = 0; i < 16; i++) begin
         win_next[i] = ext[i+RPC];
      end
   end

endmodule

// File: rtl/sha_compress_iter.sv
// -----------------------------------------------------------------------------
// sha_compress_iter
// Iterative SHA-256 compression: one 256-bit chaining state plus one 512-bit
// block in, 64 rounds executed RPC per clock, result out. Valid/ready on both
// sides; a block is accepted only in IDLE, the result is held in DONE until
// taken.
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready high only in IDLE)
//   state_in [255:0]     : chaining words a..h, a in [255:224]
//   block_in [511:0]     : message words W0..W15, W0 in [511:480]
//   out_valid / out_ready: output handshake (out_valid high only in DONE)
//   out_state [255:0]    : result words a..h, a in [255:224]
//   busy                 : high while rounds are running
// Build option SHA_COMPRESS_FEEDFORWARD_EN: when defined, out_state is the
// standard chaining output H + working state; otherwise the raw working state
// is returned and the caller does the feed-forward add.
// -----------------------------------------------------------------------------
module sha_compress_iter
   import sha256_pkg::*;
#(
   parameter int RPC   = 1,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] state_in,
   input  logic [511:0] block_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_state,
   output logic         busy
);

   generate
      if (RPC < 1 || RPC > 16 || (64 % RPC) != 0) begin : g_bad_rpc
         $error("sha_compress_iter: RPC must be one of 1, 2, 4, 8, 16");
      end
      if (CNT_W != 6) begin : g_bad_cnt_w
         $error("sha_compress_iter: CNT_W must be 6");
      end
   endgenerate

   localparam int LAST = 64 - RPC;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     rcnt_q;
   hstate_t              work_q;
   hstate_t              round_out;
   hstate_t              result;
   logic [0:15][31:0]    win_q;
   logic [0:15][31:0]    win_next;
   logic [0:RPC-1][31:0] sched;
   logic [255:0]         out_q;
   logic                 last_grp;
   logic                 accept;

   assign last_grp = (rcnt_q == CNT_W'(LAST));
   assign accept   = (state_q == ST_IDLE) && in_valid;

   sha_w_expand #(.RPC(RPC)) u_w_expand (
      .win      (win_q),
      .sched    (sched),
      .win_next (win_next)
   );

   // RPC chained rounds; round j of this cycle is overall round rcnt_q + j.
   for (genvar j = 0; j < RPC; j++) begin : g_round
      hstate_t          in_st;
      hstate_t          out_st;
      logic [CNT_W-1:0] kidx;
      word_t            t1;
      word_t            t2;

      if (j == 0) begin : g_first
         assign in_st = work_q;
      end else begin : g_chain
         assign in_st = g_round[j-1].out_st;
      end

      assign kidx   = rcnt_q + CNT_W'(j);
      assign t1     = in_st[7] + bsig1(in_st[4]) + ch(in_st[4], in_st[5], in_st[6])
                    + K[kidx] + sched[j];
      assign t2     = bsig0(in_st[0]) + maj(in_st[0], in_st[1], in_st[2]);
      assign out_st = {t1 + t2, in_st[0], in_st[1], in_st[2],
                       in_st[3] + t1, in_st[4], in_st[5], in_st[6]};
   end

   assign round_out = g_round[RPC-1].out_st;

`ifdef SHA_COMPRESS_FEEDFORWARD_EN
   hstate_t h_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_q <= '0;
      end else if (accept) begin
         h_q <= state_in;
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         result[i] = h_q[i] + round_out[i];
      end
   end
`else
   assign result = round_out;
`endif

   // NOTE: every signal written here gets a default before the case, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_grp) state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // NOTE: the 16-word window and working registers are reset like any other
   // flop; an abort must not leave a stale block visible on the next start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rcnt_q <= '0;
         work_q <= '0;
         win_q  <= '0;
         out_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  work_q <= state_in;
                  win_q  <= block_in;
                  rcnt_q <= '0;
               end
            end
            ST_RUN: begin
               work_q <= round_out;
               win_q  <= win_next;
               rcnt_q <= rcnt_q + CNT_W'(RPC);
               if (last_grp) out_q <= result;
            end
            default: ;
         endcase
      end
   end

   assign out_state = out_q;

endmodule

// File: tb/tb_sha_compress_iter.sv
// -----------------------------------------------------------------------------
// tb_sha_compress_iter
// Self-checking bench for sha_compress_iter (RPC = 4). Expected results come
// from a textbook SHA-256 compression function written out below (full 64-word
// schedule, 64-round loop) and from published digests of standard messages.
// Honours SHA_COMPRESS_FEEDFORWARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sha_compress_iter;

   localparam int RPC = 4;
   localparam int LAT = 64 / RPC;

   localparam logic [255:0] IV_S = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_2A = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};

   localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] DIG_2BLK  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic         clk;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] state_in;
   logic [511:0] block_in;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_state;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   sha_compress_iter #(.RPC(RPC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .block_in  (block_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

   // Working state after 64 rounds, before feed-forward.
   function automatic logic [255:0] ref_raw(input logic [255:0] st, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  t1, t2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = st[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i];
      return r;
   endfunction

   // What the DUT should present on out_state in this build.
   function automatic logic [255:0] ref_out(input logic [255:0] st, input logic [511:0] blk);
      logic [255:0] ff = st;
`ifndef SHA_COMPRESS_FEEDFORWARD_EN
      ff = '0;
`endif
      return add8(ref_raw(st, blk), ff);
   endfunction

   // Full chaining digest from a DUT output: adds H when the DUT does not.
   function automatic logic [255:0] to_digest(input logic [255:0] o, input logic [255:0] st);
      logic [255:0] addend = st;
`ifdef SHA_COMPRESS_FEEDFORWARD_EN
      addend = '0;
`endif
      return add8(o, addend);
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- driver tasks (enter and leave 1 time unit after posedge) ----
   task automatic send(input logic [255:0] st, input logic [511:0] blk, input string tag);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check({tag, " ready_before"}, in_ready, 1'b1);
      state_in = st;
      block_in = blk;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, " busy_after_accept"}, {busy, in_ready, out_valid}, 3'b100);
   endtask

   task automatic await_result(input string tag, output logic [255:0] res);
      int   c   = 0;
      logic bad = 1'b0;
      while (!out_valid && c < 200) begin
         @(posedge clk); #1; c++;
         if (in_ready || (busy == out_valid)) bad = 1'b1;
      end
      check({tag, " latency"}, c, LAT);
      check({tag, " flags_while_running"}, bad, 1'b0);
      check({tag, " flags_in_done"}, {busy, in_ready, out_valid}, 3'b001);
      res = out_state;
   endtask

   task automatic take(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " flags_after_take"}, {busy, in_ready, out_valid}, 3'b010);
   endtask

   task automatic run(input logic [255:0] st, input logic [511:0] blk, input string tag,
                      output logic [255:0] res);
      send(st, blk, tag);
      await_result(tag, res);
      take(tag);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [255:0] res, res2, st, st2, held;
      logic [511:0] blk, blk2;
      logic         bad_stable, bad_flags, pulse;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      state_in  = '0;
      block_in  = '0;
      #12;
      check("reset flags", {busy, in_ready, out_valid}, 3'b010);
      check("reset out_state", out_state, '0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Standard single-block vectors.
      run(IV_S, BLK_ABC, "abc", res);
      check("abc digest", to_digest(res, IV_S), DIG_ABC);
      check("abc model", res, ref_out(IV_S, BLK_ABC));

      run(IV_S, BLK_EMPTY, "empty", res);
      check("empty digest", to_digest(res, IV_S), DIG_EMPTY);

      // Random states/blocks; garbage offered on the input while running.
      for (int k = 0; k < 6; k++) begin
         st  = rand256();
         blk = rand512();
         send(st, blk, "rand");
         state_in = rand256();
         block_in = rand512();
         in_valid = 1'b1;
         await_result("rand", res);
         in_valid = 1'b0;
         check($sformatf("rand%0d result", k), res, ref_out(st, blk));
         take("rand");
      end

      // Backpressure in DONE with a live, changing input request.
      st  = rand256();
      blk = rand512();
      send(st, blk, "bp");
      await_result("bp", held);
      check("bp result", held, ref_out(st, blk));
      bad_stable = 1'b0;
      bad_flags  = 1'b0;
      in_valid   = 1'b1;
      for (int k = 0; k < 20; k++) begin
         state_in = rand256();
         block_in = rand512();
         @(posedge clk); #1;
         if (out_state !== held) bad_stable = 1'b1;
         if ({busy, in_ready, out_valid} !== 3'b001) bad_flags = 1'b1;
      end
      check("bp out_state stable", bad_stable, 1'b0);
      check("bp flags held", bad_flags, 1'b0);
      st2  = rand256();
      blk2 = rand512();
      state_in  = st2;
      block_in  = blk2;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp idle after take", {busy, in_ready, out_valid}, 3'b010);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp next accepted", {busy, in_ready, out_valid}, 3'b100);
      await_result("bp2", res);
      check("bp2 result", res, ref_out(st2, blk2));
      take("bp2");

      // Reset abort around round 30, then a clean block.
      send(IV_S, BLK_ABC, "abort");
      repeat (30 / RPC) begin
         @(posedge clk); #1;
      end
      #2 reset_n = 1'b0;
      #1;
      check("abort flags", {busy, in_ready, out_valid}, 3'b010);
      check("abort out_state", out_state, '0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      pulse = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(posedge clk); #1;
         if (out_valid || busy) pulse = 1'b1;
      end
      check("abort no result", pulse, 1'b0);
      run(IV_S, BLK_EMPTY, "after_abort", res);
      check("after_abort digest", to_digest(res, IV_S), DIG_EMPTY);

      // Two-block message chained through out_state.
      run(IV_S, BLK_2A, "blk1", res);
      st = to_digest(res, IV_S);
      check("blk1 model", res, ref_out(IV_S, BLK_2A));
      run(st, BLK_2B, "blk2", res2);
      check("two-block digest", to_digest(res2, st), DIG_2BLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
